// File: rtl/if_stage_pkg.sv
// Shared types, widths and FSM encodings for the RV64 instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0] ZERO_WORD   = '0;
  localparam logic [XLEN-1:0] IF_RESET_PC = 64'h0000_0000_8000_0000;

  localparam logic [1:0] IF_FETCH = 2'd0;
  localparam logic [1:0] IF_DROP  = 2'd1;
  localparam logic [1:0] IF_HOLD  = 2'd2;

  // Redirect targets are word-aligned silently; no misalignment exception exists.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, inst} buffer that catches an accepted fetch while IF/ID is stalled.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [XLEN-1:0]   load_pc,
  input  logic [INST_W-1:0] load_inst,
  output logic              valid,
  output logic [XLEN-1:0]   buf_pc,
  output logic [INST_W-1:0] buf_inst
);

  logic              valid_q;
  logic [XLEN-1:0]   pc_q;
  logic [INST_W-1:0] inst_q;

  // Clear wins over load: a redirect must never let a stale entry survive.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= ZERO_WORD;
      inst_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      pc_q    <= load_pc;
      inst_q  <= load_inst;
    end
  end

  assign valid    = valid_q;
  assign buf_pc   = pc_q;
  assign buf_inst = inst_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction bus and fills the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = IF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_redirect,
  input  logic [XLEN-1:0]   ex_target_pc,
  input  logic              stall_if,
  output logic              inst_req,
  output logic [XLEN-1:0]   inst_addr,
  input  logic              inst_ready,
  input  logic [INST_W-1:0] inst_rdata,
  output logic              if_valid,
  output logic [XLEN-1:0]   if_pc,
  output logic [INST_W-1:0] if_inst
);

  logic [1:0]        state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
  logic              if_valid_q, if_valid_d;
  logic [XLEN-1:0]   if_pc_q, if_pc_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;

  logic              accept;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   pc_inc;
  logic              buf_load;
  logic              buf_clear;
  logic              buf_valid;
  logic [XLEN-1:0]   buf_pc;
  logic [INST_W-1:0] buf_inst;

  assign inst_req  = !rst && ((state_q == IF_FETCH) || (state_q == IF_DROP));
  assign inst_addr = pc_q;
  assign accept    = inst_req && inst_ready;
  assign target    = align_pc(ex_target_pc);
  assign pc_inc    = pc_q + 64'd4;

  if_skid_buf u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_pc   (pc_q),
    .load_inst (inst_rdata),
    .valid     (buf_valid),
    .buf_pc    (buf_pc),
    .buf_inst  (buf_inst)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;

    case (state_q)
      IF_FETCH: begin
        if (accept) begin
          if (ex_redirect) begin
            pc_d       = target;
            if_valid_d = 1'b0;
          end else if (stall_if && if_valid_q) begin
            buf_load = 1'b1;
            pc_d     = pc_inc;
            state_d  = IF_HOLD;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_inst_d  = inst_rdata;
            pc_d       = pc_inc;
          end
        end else if (ex_redirect) begin
          // The bus still owns the old request; park the target until it completes.
          pend_pc_d  = target;
          if_valid_d = 1'b0;
          state_d    = IF_DROP;
        end else if (!stall_if) begin
          if_valid_d = 1'b0;
        end
      end

      IF_DROP: begin
        if (ex_redirect) begin
          pend_pc_d = target;
        end
        if (ex_redirect || !stall_if) begin
          if_valid_d = 1'b0;
        end
        if (accept) begin
          pc_d    = ex_redirect ? target : pend_pc_q;
          state_d = IF_FETCH;
        end
      end

      IF_HOLD: begin
        if (ex_redirect) begin
          buf_clear  = 1'b1;
          if_valid_d = 1'b0;
          pc_d       = target;
          state_d    = IF_FETCH;
        end else if (!stall_if) begin
          if_valid_d = buf_valid;
          if_pc_d    = buf_pc;
          if_inst_d  = buf_inst;
          buf_clear  = 1'b1;
          state_d    = IF_FETCH;
        end
      end

      default: begin
        state_d = IF_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IF_FETCH;
      pc_q       <= RESET_PC;
      pend_pc_q  <= ZERO_WORD;
      if_valid_q <= 1'b0;
      if_pc_q    <= ZERO_WORD;
      if_inst_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch flow, wait states, redirects, stall/skid buffer, wrap, reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_redirect;
  logic [63:0] ex_target_pc;
  logic        stall_if;
  logic        inst_req;
  logic [63:0] inst_addr;
  logic        inst_ready;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_inst;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage u_dut (
    .clk          (clk),
    .rst          (rst),
    .ex_redirect  (ex_redirect),
    .ex_target_pc (ex_target_pc),
    .stall_if     (stall_if),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_ready   (inst_ready),
    .inst_rdata   (inst_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst)
  );

  always #5 clk = ~clk;

  // Memory model: each word's contents are a fixed scramble of its address.
  function automatic logic [31:0] mem(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_0000;
  endfunction

  assign inst_rdata = mem(inst_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    ex_redirect  = 1'b0;
    ex_target_pc = '0;
    stall_if     = 1'b0;
    inst_ready   = 1'b0;
    tick();
    tick();
    check("rst_req",   64'(inst_req), 64'd0);
    check("rst_valid", 64'(if_valid), 64'd0);
    check("rst_if_pc", if_pc,         64'd0);
    check("rst_inst",  64'(if_inst),  64'd0);
    check("rst_addr",  inst_addr,     64'h8000_0000);

    // Back-to-back fetches with ready always high.
    rst        = 1'b0;
    inst_ready = 1'b1;
    #1;
    check("t1_req",    64'(inst_req), 64'd1);
    check("t1_addr0",  inst_addr,     64'h8000_0000);
    tick();
    check("t1_valid",  64'(if_valid), 64'd1);
    check("t1_pc0",    if_pc,         64'h8000_0000);
    check("t1_inst0",  64'(if_inst),  64'(mem(64'h8000_0000)));
    check("t1_addr1",  inst_addr,     64'h8000_0004);
    tick();
    check("t1_pc1",    if_pc,         64'h8000_0004);
    check("t1_addr2",  inst_addr,     64'h8000_0008);

    // Ready withheld for three cycles.
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_bubble", 64'(if_valid), 64'd0);
      check("t2_hold",   inst_addr,     64'h8000_0008);
      check("t2_req",    64'(inst_req), 64'd1);
    end
    inst_ready = 1'b1;
    tick();
    check("t2_valid",  64'(if_valid), 64'd1);
    check("t2_pc",     if_pc,         64'h8000_0008);
    check("t2_inst",   64'(if_inst),  64'(mem(64'h8000_0008)));
    check("t2_next",   inst_addr,     64'h8000_000C);

    // Redirect while the fetch of 0x..0C is still waiting.
    inst_ready   = 1'b0;
    ex_redirect  = 1'b1;
    ex_target_pc = 64'h8000_0102;
    tick();
    check("t3_valid0", 64'(if_valid), 64'd0);
    check("t3_stale",  inst_addr,     64'h8000_000C);
    check("t3_req",    64'(inst_req), 64'd1);
    ex_redirect = 1'b0;
    inst_ready  = 1'b1;
    tick();
    check("t3_addr",   inst_addr,     64'h8000_0100);
    check("t3_drop",   64'(if_valid), 64'd0);
    tick();
    check("t3_valid",  64'(if_valid), 64'd1);
    check("t3_pc",     if_pc,         64'h8000_0100);

    // Redirect into DROP, then two more redirects while still in DROP.
    inst_ready   = 1'b0;
    ex_redirect  = 1'b1;
    ex_target_pc = 64'h8800_0000;
    tick();
    ex_target_pc = 64'h9000_0000;
    tick();
    ex_target_pc = 64'hA000_0000;
    tick();
    check("t4_stale",  inst_addr,     64'h8000_0104);
    ex_redirect = 1'b0;
    inst_ready  = 1'b1;
    tick();
    check("t4_addr",   inst_addr,     64'hA000_0000);
    check("t4_drop",   64'(if_valid), 64'd0);
    tick();
    check("t4_pc",     if_pc,         64'hA000_0000);
    check("t4_valid",  64'(if_valid), 64'd1);

    // Stall on an accept with a valid entry: the skid buffer takes it.
    stall_if = 1'b1;
    tick();
    check("t5_req0",   64'(inst_req), 64'd0);
    check("t5_holdpc", if_pc,         64'hA000_0000);
    check("t5_holdv",  64'(if_valid), 64'd1);
    tick();
    check("t5_req0b",  64'(inst_req), 64'd0);
    check("t5_holdpc2", if_pc,        64'hA000_0000);
    stall_if = 1'b0;
    tick();
    check("t5_bufpc",  if_pc,         64'hA000_0004);
    check("t5_bufins", 64'(if_inst),  64'(mem(64'hA000_0004)));
    check("t5_bufv",   64'(if_valid), 64'd1);
    check("t5_addr",   inst_addr,     64'hA000_0008);
    tick();
    check("t5_nextpc", if_pc,         64'hA000_0008);
    check("t5_next",   inst_addr,     64'hA000_000C);

    // Redirect while stalled in HOLD.
    stall_if = 1'b1;
    tick();
    check("t6_hold",   64'(inst_req), 64'd0);
    ex_redirect  = 1'b1;
    ex_target_pc = 64'hB000_0007;
    tick();
    check("t6_valid0", 64'(if_valid), 64'd0);
    check("t6_req",    64'(inst_req), 64'd1);
    check("t6_addr",   inst_addr,     64'hB000_0004);
    ex_redirect = 1'b0;
    stall_if    = 1'b0;
    tick();
    check("t6_pc",     if_pc,         64'hB000_0004);
    check("t6_valid",  64'(if_valid), 64'd1);

    // PC wraps past 2^64 after an accept-cycle redirect.
    ex_redirect  = 1'b1;
    ex_target_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    check("t7_discard", 64'(if_valid), 64'd0);
    check("t7_addr",   inst_addr,     64'hFFFF_FFFF_FFFF_FFFC);
    ex_redirect = 1'b0;
    tick();
    check("t7_pc",     if_pc,         64'hFFFF_FFFF_FFFF_FFFC);
    check("t7_wrap",   inst_addr,     64'd0);

    // Reset in the middle of an outstanding fetch.
    inst_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("t8_reqdrop", 64'(inst_req), 64'd0);
    tick();
    check("t8_addr",   inst_addr,     64'h8000_0000);
    check("t8_valid",  64'(if_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
